// File: rtl/sipo_word_assembler.sv
// Serial-in, parallel-out word assembler.
// Collects qualified serial bits into N-bit words and holds each completed word
// in an output register with a valid/ready handshake. The shift register keeps
// assembling the next word while the previous one waits downstream.
module sipo_word_assembler #(
   parameter int unsigned N         = 4,
   parameter int unsigned MSB_FIRST = 1,
   localparam int unsigned CntW     = (N > 2) ? $clog2(N) : 1
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_serial_in,
   input  logic            i_serial_valid,
   input  logic            i_clear,
   input  logic            i_word_ready,
   output logic [N-1:0]    o_parallel_out,
   output logic            o_word_valid,
   output logic            o_load,
   output logic [CntW-1:0] o_bit_count,
   output logic            o_overrun
);

   typedef enum logic [0:0] {StEmpty, StFull} hold_state_e;

   hold_state_e     state_q, state_d;
   logic [N-1:0]    sr_q, sr_d;
   logic [N-1:0]    sr_shift;
   logic [N-1:0]    hold_q, hold_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            overrun_q, overrun_d;
   logic            complete;
   logic            load_hold;
   logic            drop_word;

   // Shift path: next shift-register value and word-completion detect.
   always_comb begin
      sr_shift = sr_q;
      if (MSB_FIRST != 0) begin
         sr_shift = {sr_q[N-2:0], i_serial_in};
      end else begin
         sr_shift = {i_serial_in, sr_q[N-1:1]};
      end
      complete = i_serial_valid && (cnt_q == CntW'(N - 1));
   end

   // Next-state for the shift register and bit counter; clear wins over any bit.
   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (i_clear) begin
         sr_d  = '0;
         cnt_d = '0;
      end else if (i_serial_valid) begin
         sr_d  = sr_shift;
         cnt_d = complete ? '0 : cnt_q + CntW'(1);
      end
   end

   // Holding FSM: state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StEmpty;
      end else begin
         state_q <= state_d;
      end
   end

   // Holding FSM: next state.
   always_comb begin
      state_d = state_q;
      if (i_clear) begin
         state_d = StEmpty;
      end else begin
         unique case (state_q)
            StEmpty: if (complete) state_d = StFull;
            // A completion with ready replaces the consumed word and stays full.
            StFull:  if (i_word_ready && !complete) state_d = StEmpty;
            default: state_d = StEmpty;
         endcase
      end
   end

   // Holding FSM: outputs and datapath controls.
   always_comb begin
      load_hold = 1'b0;
      drop_word = 1'b0;
      unique case (state_q)
         StEmpty: load_hold = complete;
         StFull: begin
            load_hold = complete && i_word_ready;
            drop_word = complete && !i_word_ready;
         end
         default: ;
      endcase
      o_word_valid = (state_q == StFull);
      // Combinational so downstream loads on the same edge it sees ready.
      o_load       = o_word_valid && i_word_ready;
   end

   // Holding register and sticky overrun next-state.
   always_comb begin
      hold_d    = hold_q;
      overrun_d = overrun_q;
      if (i_clear) begin
         hold_d    = '0;
         overrun_d = 1'b0;
      end else begin
         if (load_hold) hold_d = sr_shift;
         if (drop_word) overrun_d = 1'b1;
      end
   end

   // Datapath registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sr_q      <= '0;
         cnt_q     <= '0;
         hold_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
         overrun_q <= overrun_d;
      end
   end

   assign o_parallel_out = hold_q;
   assign o_bit_count    = cnt_q;
   assign o_overrun      = overrun_q;

endmodule

// File: tb/tb_sipo_word_assembler.sv
// Self-checking bench: an MSB-first and an LSB-first instance share one stimulus
// stream and are compared every cycle against a bit-list reference model.
module tb_sipo_word_assembler;

   localparam int unsigned N = 4;

   logic         clk;
   logic         rst_n;
   logic         ser_in;
   logic         ser_valid;
   logic         clr;
   logic         rdy;

   logic [N-1:0] m_out,  l_out;
   logic         m_valid, l_valid;
   logic         m_load,  l_load;
   logic [1:0]   m_cnt,   l_cnt;
   logic         m_ovr,   l_ovr;

   int n_cmp;
   int n_err;

   // Reference model state.
   bit           part[$];
   bit           e_valid;
   bit           e_over;
   logic [N-1:0] e_word_msb;
   logic [N-1:0] e_word_lsb;

   sipo_word_assembler #(.N(N), .MSB_FIRST(1)) u_msb (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_serial_in    (ser_in),
      .i_serial_valid (ser_valid),
      .i_clear        (clr),
      .i_word_ready   (rdy),
      .o_parallel_out (m_out),
      .o_word_valid   (m_valid),
      .o_load         (m_load),
      .o_bit_count    (m_cnt),
      .o_overrun      (m_ovr)
   );

   sipo_word_assembler #(.N(N), .MSB_FIRST(0)) u_lsb (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_serial_in    (ser_in),
      .i_serial_valid (ser_valid),
      .i_clear        (clr),
      .i_word_ready   (rdy),
      .o_parallel_out (l_out),
      .o_word_valid   (l_valid),
      .o_load         (l_load),
      .o_bit_count    (l_cnt),
      .o_overrun      (l_ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      part.delete();
      e_valid    = 1'b0;
      e_over     = 1'b0;
      e_word_msb = '0;
      e_word_lsb = '0;
   endtask

   // Word value from the ordered list of received bits.
   task automatic model_edge(input bit v, input bit b, input bit c, input bit r);
      bit           done;
      logic [N-1:0] wm, wl;
      done = 1'b0;
      wm   = '0;
      wl   = '0;
      if (c) begin
         model_reset();
         return;
      end
      if (v) begin
         part.push_back(b);
         if (part.size() == N) begin
            done = 1'b1;
            for (int i = 0; i < N; i++) begin
               if (part[i]) begin
                  wm = wm + N'(1 << (N - 1 - i));
                  wl = wl + N'(1 << i);
               end
            end
            part.delete();
         end
      end
      if (done) begin
         if (!e_valid || r) begin
            e_valid    = 1'b1;
            e_word_msb = wm;
            e_word_lsb = wl;
         end else begin
            e_over = 1'b1;
         end
      end else if (e_valid && r) begin
         e_valid = 1'b0;
      end
   endtask

   task automatic check_all();
      bit exp_load;
      exp_load = e_valid && rdy;
      check("msb_cnt",   32'(m_cnt),   32'(part.size()));
      check("msb_valid", 32'(m_valid), 32'(e_valid));
      check("msb_ovr",   32'(m_ovr),   32'(e_over));
      check("msb_load",  32'(m_load),  32'(exp_load));
      check("msb_word",  32'(m_out),   32'(e_word_msb));
      check("lsb_cnt",   32'(l_cnt),   32'(part.size()));
      check("lsb_valid", 32'(l_valid), 32'(e_valid));
      check("lsb_ovr",   32'(l_ovr),   32'(e_over));
      check("lsb_load",  32'(l_load),  32'(exp_load));
      check("lsb_word",  32'(l_out),   32'(e_word_lsb));
   endtask

   // One clock: drive after the falling edge, check, then advance the model.
   task automatic step(input bit v, input bit b, input bit c, input bit r);
      @(negedge clk);
      ser_valid = v;
      ser_in    = b;
      clr       = c;
      rdy       = r;
      #1;
      check_all();
      @(posedge clk);
      model_edge(v, b, c, r);
   endtask

   // Send a 4-bit pattern, first bit = w[3], with 'gap' idle cycles after each bit.
   task automatic send_word(input logic [3:0] w, input int gap, input bit r);
      logic [3:0] pat;
      pat = w;
      for (int i = 3; i >= 0; i--) begin
         step(1'b1, pat[i], 1'b0, r);
         for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, r);
      end
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      ser_in    = 1'b0;
      ser_valid = 1'b0;
      clr       = 1'b0;
      rdy       = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // MSB-first word with ready high, then idle to see valid drop.
      send_word(4'b1011, 0, 1'b1);
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);

      // Gapped input.
      send_word(4'b0110, 2, 1'b1);
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);

      // Backpressure overrun, then release ready.
      send_word(4'b1011, 0, 1'b0);
      send_word(4'b0110, 0, 1'b0);
      repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);

      // Clear flushes the overrun and partial word.
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // Back-to-back with ready held.
      send_word(4'b1011, 0, 1'b1);
      send_word(4'b0110, 0, 1'b1);
      repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);

      // LSB-first pattern, partial word, clear with a bit on the same edge, clean word.
      send_word(4'b1000, 0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      send_word(4'b1101, 0, 1'b1);
      repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 2) != 0));
      end

      // Asynchronous reset mid-cycle with random bus values and held state.
      send_word(4'b1111, 0, 1'b0);
      send_word(4'b1010, 0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      ser_valid = 1'($urandom_range(0, 1));
      ser_in    = 1'($urandom_range(0, 1));
      rdy       = 1'($urandom_range(0, 1));
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst_n     = 1'b1;
      ser_valid = 1'b0;
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
      send_word(4'b0101, 0, 1'b1);
      repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
